// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and bit-timing helpers.
// Used by uart_rx (and uart_tx). Optional receive hold mode is selected by UART_RX_HOLD_EN.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_LVL = 1'b0;
    localparam logic        STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_WAIT   = 3'd5
    } uart_state_e;

    // Received byte plus its error flags, updated together on completion
    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 frame_err;
        logic                 parity_err;
    } uart_rx_result_t;

    // System clocks per bit period (integer division)
    function automatic int unsigned calc_rate(input int unsigned clock_rate,
                                              input int unsigned baud_rate);
        return clock_rate / baud_rate;
    endfunction

    // Clocks from the start edge to the middle of the start bit
    function automatic int unsigned calc_half(input int unsigned clock_rate,
                                              input int unsigned baud_rate);
        return calc_rate(clock_rate, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side bus of the UART receiver. master = receiver, slave = byte consumer.
// With UART_RX_HOLD_EN defined the bus adds the ack/overrun handshake.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;
`ifdef UART_RX_HOLD_EN
    logic                 ack;
    logic                 overrun;

    modport master (
        output data, valid, frame_err, parity_err, busy, overrun,
        input  ack
    );

    modport slave (
        input  data, valid, frame_err, parity_err, busy, overrun,
        output ack
    );
`else
    modport master (
        output data, valid, frame_err, parity_err, busy
    );

    modport slave (
        input  data, valid, frame_err, parity_err, busy
    );
`endif

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level
// so the output matches the idle level of the line it guards.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; the first stage may go metastable, the second settles it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB first, optional even parity, 1 stop.
// Samples the synchronized line at mid-bit and reports each byte with error flags.
// Define UART_RX_HOLD_EN to turn valid into a level held until ack, with overrun detect.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned PARITY     = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int unsigned RATE  = calc_rate(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned HALF  = calc_half(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned WIDTH = $clog2(RATE);
    localparam int unsigned CW    = WIDTH + 1;
    localparam int unsigned IW    = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_BIT  = CW'(RATE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [IW-1:0]        idx, idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 par_bit, par_next;
    logic                 done_c;
    uart_rx_result_t      res_c;
    uart_rx_result_t      result;
    logic                 valid;
    logic                 busy;
`ifdef UART_RX_HOLD_EN
    logic                 overrun;
`endif

    sync_2ff #(
        .RESET_VAL (STOP_LVL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Frame state, bit timer, bit index and shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            idx     <= idx_next;
            shift   <= shift_next;
            par_bit <= par_next;
        end
    end

    // Next-state decode: one sample per bit, taken when the bit timer expires
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        idx_next   = idx;
        shift_next = shift;
        par_next   = par_bit;
        done_c     = 1'b0;

        unique case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (rx_s == START_LVL) begin
                    state_next = S_START;
                end
            end

            S_START: begin
                if (cnt == CNT_HALF) begin
                    if (rx_s == START_LVL) begin
                        state_next = S_DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (cnt == CNT_BIT) begin
                    shift_next[idx] = rx_s;
                    idx_next        = idx + IW'(1);
                    if (idx == IDX_LAST) begin
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end

            S_PARITY: begin
                if (cnt == CNT_BIT) begin
                    par_next   = rx_s;
                    state_next = S_STOP;
                end
            end

            S_STOP: begin
                if (cnt == CNT_BIT) begin
                    done_c     = 1'b1;
                    state_next = (rx_s == STOP_LVL) ? S_IDLE : S_WAIT;
                end
            end

            S_WAIT: begin
                cnt_next = '0;
                if (rx_s == STOP_LVL) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Timer restarts on every state change and at the end of each bit period
        if ((state_next != state) || (cnt == CNT_BIT)) begin
            cnt_next = '0;
        end
    end

    // Completed-frame payload evaluated at the stop-bit sample
    assign res_c = '{
        data:       shift,
        frame_err:  (rx_s != STOP_LVL),
        parity_err: (PARITY != 0) && (par_bit != ^shift)
    };

    // Registered byte-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result  <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
`ifdef UART_RX_HOLD_EN
            overrun <= 1'b0;
`endif
        end else begin
            busy <= (state_next != S_IDLE);
            if (done_c) begin
                result <= res_c;
            end
`ifdef UART_RX_HOLD_EN
            if (done_c) begin
                valid   <= 1'b1;
                overrun <= valid && !bus.ack;
            end else if (bus.ack) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
`else
            valid <= done_c;
`endif
        end
    end

    assign bus.data       = result.data;
    assign bus.frame_err  = result.frame_err;
    assign bus.parity_err = result.parity_err;
    assign bus.valid      = valid;
    assign bus.busy       = busy;
`ifdef UART_RX_HOLD_EN
    assign bus.overrun    = overrun;
`endif

endmodule
